// File: rtl/spi_ctrl_master.sv
// Byte-wide SPI mode-0 master that stands in for the board microcontroller.
// Shifts cmd_data out MSB first on SPI_DI, samples SPI_DO, and can hold a select across bytes.
module spi_ctrl_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [1:0] cmd_ss,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_DI,
    input  logic       SPI_DO,
    output logic       CONF_DATA0,
    output logic       SPI_SS2,
    output logic       SPI_SS3
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, TAIL, DESEL} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, tx, rx;
    logic [2:0] bit_idx;
    logic [1:0] ss_q, sel_ss;
    logic       last_q, pend_q, rdy_en, sel_on;
    logic       accept, phase_done, byte_end;

    assign accept     = cmd_valid & cmd_ready;
    assign phase_done = (cnt == 8'd0);
    assign byte_end   = (state == HIGH) && phase_done && (bit_idx == 3'd0);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: if (phase_done) state_nxt = HIGH;
            HIGH:  if (phase_done) state_nxt = (bit_idx != 3'd0) ? LOW : (last_q ? TAIL : HOLD);
            LOW:   if (phase_done) state_nxt = HIGH;
            HOLD:  if (accept) state_nxt = (cmd_ss == sel_ss) ? SETUP : TAIL;
            TAIL:  if (phase_done) state_nxt = DESEL;
            DESEL: if (phase_done) state_nxt = pend_q ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every phase entry is a state change, so a state change reloads the half-period count.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt       <= 8'd0;
            tx        <= 8'd0;
            rx        <= 8'd0;
            bit_idx   <= 3'd0;
            ss_q      <= 2'd3;
            sel_ss    <= 2'd3;
            last_q    <= 1'b0;
            pend_q    <= 1'b0;
            rdy_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
        end else begin
            rdy_en    <= 1'b1;
            rsp_valid <= byte_end;
            if (state_nxt != state)  cnt <= 8'(CLK_DIV - 1);
            else if (!phase_done)    cnt <= cnt - 8'd1;
            if (accept) begin
                tx      <= cmd_data;
                ss_q    <= cmd_ss;
                last_q  <= cmd_last;
                bit_idx <= 3'd7;
                // A select change out of HOLD keeps the old line low through TAIL.
                if (state == IDLE || cmd_ss == sel_ss) begin
                    sel_ss <= cmd_ss;
                    pend_q <= 1'b0;
                end else begin
                    pend_q <= 1'b1;
                end
            end
            if (state == DESEL && phase_done && pend_q) begin
                sel_ss <= ss_q;
                pend_q <= 1'b0;
            end
            if (state == HIGH && cnt == 8'(CLK_DIV - 1))
                rx <= {rx[6:0], SPI_DO};
            if (state == HIGH && phase_done && bit_idx != 3'd0) begin
                tx      <= {tx[6:0], 1'b0};
                bit_idx <= bit_idx - 3'd1;
            end
            if (byte_end) rsp_data <= rx;
        end
    end

    always_comb begin
        SPI_SCK   = (state == HIGH);
        SPI_DI    = 1'b0;
        sel_on    = 1'b0;
        cmd_ready = rdy_en && (state == IDLE || state == HOLD);
        busy      = (state != IDLE);
        case (state)
            SETUP, HIGH, LOW: begin
                SPI_DI = tx[7];
                sel_on = 1'b1;
            end
            HOLD, TAIL: sel_on = 1'b1;
            default: ;
        endcase
        CONF_DATA0 = !(sel_on && sel_ss == 2'd0);
        SPI_SS2    = !(sel_on && sel_ss == 2'd1);
        SPI_SS3    = !(sel_on && sel_ss == 2'd2);
    end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Bench for spi_ctrl_master: two instances (CLK_DIV 4 and 2) checked every cycle
// against a timeline model painted from each accepted command.
module tb_spi_ctrl_master;
    localparam int N = 4096;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [1:0] cmd_valid, cmd_last, tie1;
    logic [7:0] cmd_data [2];
    logic [1:0] cmd_ss [2];
    logic [1:0] cmd_ready, rsp_valid, busy, sck, spi_di, spi_do, cd0, ss2, ss3;
    logic [7:0] rsp_data [2];

    always #5 CLOCK_50 = ~CLOCK_50;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_ctrl_master #(.CLK_DIV(g == 0 ? 4 : 2)) u_dut (
            .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_data(cmd_data[g]), .cmd_ss(cmd_ss[g]), .cmd_last(cmd_last[g]),
            .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]), .busy(busy[g]),
            .SPI_SCK(sck[g]), .SPI_DI(spi_di[g]), .SPI_DO(spi_do[g]),
            .CONF_DATA0(cd0[g]), .SPI_SS2(ss2[g]), .SPI_SS3(ss3[g])
        );
        assign spi_do[g] = tie1[g] ? 1'b1 : spi_di[g];
    end

    // Expected waveform per instance, indexed by cycle (the interval after clock edge n).
    logic       e_sck [2][N], e_busy [2][N], e_rdy [2][N], e_rv [2][N], e_dchk [2][N], e_di [2][N];
    logic [1:0] e_sel [2][N];
    logic [7:0] e_rd  [2][N];
    int div [2] = '{4, 2};
    int hold_ss [2], end_cyc [2], acc_cnt [2], acc_cyc [2], rv_cnt [2];
    int cyc = 0, errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] sel_vec(input logic [1:0] s);
        case (s)
            2'd0: return 3'b110;
            2'd1: return 3'b101;
            2'd2: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    task automatic fill(input int i, input int from, input int to, input logic s_ck, input int sel,
                        input logic bsy, input logic rdy, input logic dchk, input logic di);
        for (int t = from; t < to && t < N; t++) begin
            e_sck[i][t] = s_ck; e_sel[i][t] = 2'(sel); e_busy[i][t] = bsy; e_rdy[i][t] = rdy;
            e_rv[i][t] = 1'b0; e_dchk[i][t] = dchk; e_di[i][t] = di;
        end
    endtask

    task automatic set_rd(input int i, input int from, input logic [7:0] v);
        for (int t = from; t < N; t++) e_rd[i][t] = v;
    endtask

    // A byte is 16 half-periods (setup, then HIGH/LOW alternating, ending on HIGH).
    task automatic paint_accept(input int i, input int e, input logic [7:0] d, input int ss,
                                input logic last, input logic t1);
        int dv, s, r;
        dv = div[i];
        s = e;
        if (hold_ss[i] >= 0 && hold_ss[i] != ss) begin
            fill(i, e, e + dv, 0, hold_ss[i], 1, 0, 0, 0);
            fill(i, e + dv, e + 2 * dv, 0, 3, 1, 0, 0, 0);
            s = e + 2 * dv;
        end
        for (int k = 0; k < 16; k++)
            fill(i, s + k * dv, s + (k + 1) * dv, logic'(k % 2), ss, 1, 0, 1, d[7 - k / 2]);
        r = s + 16 * dv;
        if (last) begin
            fill(i, r, r + dv, 0, ss, 1, 0, 0, 0);
            fill(i, r + dv, r + 2 * dv, 0, 3, 1, 0, 0, 0);
            fill(i, r + 2 * dv, N, 0, 3, 0, 1, 0, 0);
            hold_ss[i] = -1;
            end_cyc[i] = r + 2 * dv;
        end else begin
            fill(i, r, N, 0, ss, 1, 1, 0, 0);
            hold_ss[i] = ss;
            end_cyc[i] = r;
        end
        if (r < N) e_rv[i][r] = 1'b1;
        set_rd(i, r, t1 ? 8'hFF : d);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            fill(i, cyc, N, 0, 3, 0, 0, 0, 0);
            set_rd(i, cyc, 8'h00);
            hold_ss[i] = -1;
            end_cyc[i] = cyc;
        end
    endtask

    task automatic model_release();
        for (int i = 0; i < 2; i++) fill(i, cyc + 1, N, 0, 3, 0, 1, 0, 0);
    endtask

    always @(posedge CLOCK_50) begin
        for (int i = 0; i < 2; i++)
            if (RESET_N && cmd_valid[i] && cyc < N && e_rdy[i][cyc]) begin
                paint_accept(i, cyc + 1, cmd_data[i], int'(cmd_ss[i]), cmd_last[i], tie1[i]);
                acc_cnt[i]++;
                acc_cyc[i] = cyc + 1;
            end
        cyc++;
    end

    always @(negedge CLOCK_50) begin
        if (cyc >= 1 && cyc < N)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("outputs%0d", i),
                    {17'd0, sck[i], ss3[i], ss2[i], cd0[i], busy[i], cmd_ready[i], rsp_valid[i], rsp_data[i]},
                    {17'd0, e_sck[i][cyc], sel_vec(e_sel[i][cyc]), e_busy[i][cyc], e_rdy[i][cyc],
                     e_rv[i][cyc], e_rd[i][cyc]});
                chk($sformatf("one_select%0d", i), 32'($countones(~{ss3[i], ss2[i], cd0[i]}) <= 1), 32'd1);
                if (e_dchk[i][cyc]) chk($sformatf("mosi%0d", i), 32'(spi_di[i]), 32'(e_di[i][cyc]));
                if (rsp_valid[i]) rv_cnt[i]++;
            end
    end

    task automatic send(input int i, input logic [7:0] d, input logic [1:0] ss, input logic last,
                        input logic keep);
        int n0;
        n0 = acc_cnt[i];
        cmd_data[i] = d; cmd_ss[i] = ss; cmd_last[i] = last; cmd_valid[i] = 1'b1;
        for (int k = 0; k < 3000 && acc_cnt[i] == n0; k++) @(negedge CLOCK_50);
        chk("accept_seen", 32'(acc_cnt[i] != n0), 32'd1);
        if (!keep) cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 3000 && cyc <= end_cyc[i]; k++) @(negedge CLOCK_50);
        chk("done_in_time", 32'(cyc > end_cyc[i]), 32'd1);
    endtask

    initial begin
        int e, rises, hi, rv0;
        logic p;
        RESET_N = 1'b0;
        cmd_valid = '0; cmd_last = '0; tie1 = '0;
        for (int i = 0; i < 2; i++) begin
            cmd_data[i] = 8'h00; cmd_ss[i] = 2'd3; acc_cnt[i] = 0; rv_cnt[i] = 0;
        end
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        chk("rst_ready", 32'(cmd_ready[0]), 32'd0);
        chk("rst_pins", {27'd0, sck[0], spi_di[0], cd0[0], ss2[0], ss3[0]}, 32'b00111);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        model_release();
        @(negedge CLOCK_50);
        chk("ready_after_release", 32'(cmd_ready[0]), 32'd1);

        // Single byte, loopback, CLK_DIV=4: pinned against hand-computed cycle offsets.
        send(0, 8'hA5, 2'd1, 1'b1, 1'b0);
        e = acc_cyc[0]; rises = 0; hi = 0; p = 1'b0;
        for (int off = 0; off <= 72; off++) begin
            if (off > 0) @(negedge CLOCK_50);
            if (sck[0] && !p) rises++;
            if (sck[0]) hi++;
            p = sck[0];
            if (off == 64) chk("rsp_at_64", {23'd0, rsp_valid[0], rsp_data[0]}, {23'd0, 1'b1, 8'hA5});
            if (off == 67) chk("ss2_low_67", 32'(ss2[0]), 32'd0);
            if (off == 68) chk("ss2_high_68", 32'(ss2[0]), 32'd1);
            if (off == 71) chk("ready_71", 32'(cmd_ready[0]), 32'd0);
            if (off == 72) chk("ready_72", 32'(cmd_ready[0]), 32'd1);
        end
        chk("sck_pulses", 32'(rises), 32'd8);
        chk("sck_high_cycles", 32'(hi), 32'd32);
        chk("first_accept_cyc", 32'(e), 32'(acc_cyc[0]));

        // Three-byte burst holding CONF_DATA0.
        rv0 = rv_cnt[0];
        send(0, 8'h14, 2'd0, 1'b0, 1'b0);
        send(0, 8'h00, 2'd0, 1'b0, 1'b0);
        send(0, 8'hFF, 2'd0, 1'b1, 1'b0);
        wait_done(0);
        chk("burst_rsp_count", 32'(rv_cnt[0] - rv0), 32'd3);
        chk("burst_last_data", 32'(rsp_data[0]), 32'hFF);

        // HOLD on CONF_DATA0, then switch to SPI_SS3.
        send(0, 8'h3C, 2'd0, 1'b0, 1'b0);
        send(0, 8'h5A, 2'd2, 1'b1, 1'b0);
        wait_done(0);
        chk("switch_data", 32'(rsp_data[0]), 32'h5A);

        // Dummy clocks with MISO tied high.
        tie1[0] = 1'b1;
        send(0, 8'hFF, 2'd3, 1'b1, 1'b0);
        wait_done(0);
        chk("dummy_data", 32'(rsp_data[0]), 32'hFF);
        tie1[0] = 1'b0;

        // Reset three bits into a byte.
        send(0, 8'h96, 2'd1, 1'b1, 1'b0);
        repeat (28) @(posedge CLOCK_50);
        #1 RESET_N = 1'b0;
        model_reset();
        #1;
        chk("midrst_pins", {27'd0, sck[0], spi_di[0], cd0[0], ss2[0], ss3[0]}, 32'b00111);
        chk("midrst_flags", {29'd0, rsp_valid[0], cmd_ready[0], busy[0]}, 32'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        model_release();
        send(0, 8'hC3, 2'd1, 1'b1, 1'b0);
        wait_done(0);
        chk("post_reset_data", 32'(rsp_data[0]), 32'hC3);

        // cmd_valid held high across four bytes, CLK_DIV=2.
        rv0 = rv_cnt[1];
        send(1, 8'h11, 2'd1, 1'b1, 1'b1);
        send(1, 8'h22, 2'd1, 1'b0, 1'b1);
        send(1, 8'h33, 2'd1, 1'b0, 1'b1);
        send(1, 8'h44, 2'd1, 1'b1, 1'b0);
        wait_done(1);
        chk("stream_rsp_count", 32'(rv_cnt[1] - rv0), 32'd4);
        chk("stream_accepts", 32'(acc_cnt[1]), 32'd4);
        chk("stream_last_data", 32'(rsp_data[1]), 32'h44);

        repeat (4) @(negedge CLOCK_50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_ctrl_master.md
Name: spi_ctrl_master

Overview:
- Byte-wide SPI mode-0 master: the controller-side initiator for the FPGA's SPI slave bus (user_io on CONF_DATA0, data_io on SPI_SS2, OSD on SPI_SS3).
- Used in bench/standalone builds in place of the board microcontroller: it drives SCK, MOSI (SPI_DI) and the three active-low selects, and samples MISO (SPI_DO).
- Command/response handshake toward a local sequencer; chip-select can be held across multi-byte commands.

Parameters:
- CLK_DIV, 4, SCK half-period in CLOCK_50 cycles; legal range 2..255; SCK frequency = CLOCK_50/(2*CLK_DIV).

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command byte offered.
- cmd_ready  out  1  master can accept a byte.
- cmd_data  in  8  byte to shift out, MSB first.
- cmd_ss  in  2  select: 0=CONF_DATA0, 1=SPI_SS2, 2=SPI_SS3, 3=none (dummy clocks).
- cmd_last  in  1  deassert select after this byte.
- rsp_valid  out  1  one-cycle pulse, received byte valid.
- rsp_data  out  8  byte sampled from SPI_DO.
- busy  out  1  high in any state other than IDLE.
- SPI_SCK  out  1  serial clock, idle low.
- SPI_DI  out  1  MOSI.
- SPI_DO  in  1  MISO; sampled on SCK rising edge.
- CONF_DATA0, SPI_SS2, SPI_SS3  out  1 each  active-low selects.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): SPI_SCK=0, SPI_DI=0, all selects=1, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE. cmd_ready rises on the first clock after RESET_N deasserts.
- States: IDLE, SETUP, HIGH, LOW, HOLD, TAIL, DESEL. Half-period counter reloads with CLK_DIV-1 on each phase entry.
- Accept: cmd_valid&cmd_ready. cmd_ready=1 only in IDLE and HOLD. Accepting latches data, ss and last.
- SETUP (CLK_DIV cycles): selected line low, SPI_DI=bit7, SCK low.
- HIGH (CLK_DIV cycles): SCK=1. SPI_DO is shifted in on the first cycle of HIGH.
- LOW (CLK_DIV cycles): SCK=0, SPI_DI presents the next bit. Phases alternate HIGH/LOW for bits 7..1; HIGH for bit 0 ends the byte.
- Byte end: SCK returns low and rsp_valid pulses with rsp_data, exactly 16*CLK_DIV cycles after the accept cycle.
- rsp_data holds its value until the next byte completes.
- Byte end with last=0: go to HOLD. Select stays low, SCK low, ready=1.
  - HOLD + accept with the same ss: go to SETUP.
  - HOLD + accept with a different ss: go to TAIL, then DESEL, then SETUP with the new select.
  - HOLD with no command: remain in HOLD indefinitely.
- Byte end with last=1: go to TAIL (CLK_DIV cycles, select low, SCK low), then DESEL (CLK_DIV cycles, all selects high), then IDLE.
- ss=3: full clocking, no select asserted. Used for dummy cycles.
- At most one select is low at any time. Select changes only while SCK=0.
- cmd_valid while not ready: ignored; the data is not latched.
- busy = (state != IDLE).

Test Plan:
- Loopback SPI_DI->SPI_DO, CLK_DIV=4: send 0xA5, ss=1, last=1 -> SPI_SS2 low throughout; 8 SCK pulses, 4 high/4 low; rsp_valid at cycle 64 with rsp_data=0xA5; SS2 high at cycle 68; cmd_ready at cycle 72.
- Burst of 0x14, 0x00, 0xFF on ss=0, last only on the third byte -> CONF_DATA0 stays low across all three bytes; three rsp_valid pulses returning the looped bytes; no select glitch between bytes.
- HOLD on ss=0, then a command with ss=2 -> CONF_DATA0 rises, at least CLK_DIV cycles with all selects high, then SPI_SS3 falls; never two selects low at once.
- ss=3 with 0xFF and SPI_DO tied 1 -> all selects high, 8 clocks, rsp_data=0xFF.
- RESET_N pulsed low mid-byte (after 3 bits) -> SCK=0, selects=1, rsp_valid=0 in the same cycle; a fresh command after release completes normally.
- cmd_valid held high continuously with CLK_DIV=2 -> each byte accepted exactly once; rsp_valid spacing matches the FSM timing; no dropped or duplicated bytes.
